freq_div_ctrl: RTL
==================

FREQ_DIV_CTRL -- requirements
Module: freq_div_ctrl

Interface
REQ-001 The module SHALL have parameter DIV_W, default 8, meaning the divisor width in bits.
REQ-002 The module SHALL have parameter DEF_DIV, default 4, meaning the divisor loaded at reset (legal range 2..2^DIV_W-1).
REQ-003 Port clk SHALL be an input, 1 bit, and is the single system clock; all logic uses its rising edge.
REQ-004 Port rst SHALL be an input, 1 bit; it is the asynchronous, active-low reset.
REQ-005 Port enable SHALL be an input, 1 bit; it requests divided-clock generation.
REQ-006 Port cfg_valid SHALL be an input, 1 bit; it marks that a new divisor is offered.
REQ-007 Port cfg_div SHALL be an input, DIV_W bits; it carries the requested divisor N.
REQ-008 Port cfg_ready SHALL be an output, 1 bit; a transfer occurs when cfg_valid and cfg_ready are both 1 on an edge.
REQ-009 Port cfg_err SHALL be an output, 1 bit; it is a one-cycle pulse flagging a rejected divisor.
REQ-010 Port clk_out SHALL be an output, 1 bit; it carries the registered divided clock.
REQ-011 Port tick SHALL be an output, 1 bit; it is a one-cycle pulse on the first high cycle of each clk_out period.
REQ-012 Port cur_div SHALL be an output, DIV_W bits; it carries the divisor currently in effect.
REQ-013 Port busy SHALL be an output, 1 bit; it is 1 in every state except IDLE.

Function
REQ-014 The FSM SHALL have exactly three states: IDLE (clk_out=0), RUN, and PEND (new divisor accepted, awaiting period boundary).
REQ-015 A period with divisor N SHALL be N clk cycles: clk_out=1 for floor(N/2) cycles, then 0 for ceil(N/2) cycles (N=4 gives 2 high, 2 low; N=5 gives 2 high, 3 low).
REQ-016 IDLE->RUN SHALL occur on the first edge with enable=1; clk_out and tick SHALL be 1 in the cycle following that edge (latency 1).
REQ-017 A period boundary SHALL be the edge ending the last low cycle; no partial period, runt pulse or glitch is ever produced.
REQ-018 cfg_ready SHALL be 1 in IDLE and RUN, and 0 in PEND.
REQ-019 A transfer with cfg_div<2 SHALL be consumed without state change, and cfg_err SHALL be 1 in the following cycle.
REQ-020 A valid transfer in IDLE SHALL update cur_div on the same edge.
REQ-021 A valid transfer in RUN SHALL move the FSM to PEND; at the next boundary cur_div SHALL take the new value, the FSM SHALL return to RUN, and the next period SHALL use the new N.
REQ-022 If the transfer edge is itself a boundary, the new N SHALL apply from the immediately following period.
REQ-023 enable=0 sampled in RUN or PEND SHALL complete the current period; at the boundary the FSM SHALL go to IDLE, applying any pending divisor first.
REQ-024 If enable falls and a transfer occurs on the same edge, both SHALL be honoured.
REQ-025 enable re-asserted before the boundary SHALL cancel the stop, with no gap in clk_out.
REQ-026 The period counter SHALL be DIV_W bits and SHALL wrap from N-1 to 0 at the boundary only; it SHALL never be compared against an unapplied divisor.

Reset
REQ-027 rst=0 SHALL immediately force: FSM=IDLE, clk_out=0, tick=0, cfg_err=0, busy=0, cur_div=DEF_DIV, counter=0, pending divisor cleared, cfg_ready=1.
REQ-028 Reset asserted mid-period SHALL abort the period with no pending state surviving; operation SHALL resume only via REQ-016 after release.

Structure
REQ-029 Package freq_div_pkg SHALL hold DIV_W, DIV_MIN=2, and the state enumeration {IDLE, RUN, PEND}.
REQ-030 Sub-module freq_div_core SHALL contain the counter and clk_out/tick generation, taking a divisor plus a load strobe and returning a boundary flag; freq_div_ctrl SHALL hold the FSM and handshake logic.

Verification
REQ-031 Reset release, enable=1, no cfg: clk_out SHALL be 1100 repeating (80 ns period at 50 MHz clk), tick every 4 cycles, cur_div=4.
REQ-032 In RUN, cfg_div=6 accepted mid-period: the current 4-cycle period SHALL complete, then 111000 SHALL repeat; cfg_ready=0 until the boundary.
REQ-033 cfg_div=1, then cfg_div=0: cfg_err SHALL pulse once per transfer, and cur_div and the clk_out pattern SHALL be unchanged.
REQ-034 N=5, enable dropped in the second high cycle: the output SHALL be 11000 completed, then IDLE with busy=0 and clk_out=0.
REQ-035 rst asserted during a high cycle with a divisor pending: clk_out=0 immediately, cur_div=4 after release, and no stale divisor SHALL be applied.
REQ-036 Falling enable and cfg_div=3 on the same edge: the period SHALL finish, then IDLE with cur_div=3; re-enable SHALL give 100 repeating.

Source files
------------

// File: rtl/freq_div_pkg.sv
// Shared constants and FSM state encoding for the programmable clock divider.
package freq_div_pkg;

    // Default divisor width and the smallest divisor that still yields a high phase.
    localparam int unsigned DIV_W   = 8;
    localparam int unsigned DIV_MIN = 2;

    // Controller states, kept as plain constants so older tools can consume them.
    typedef logic [1:0] state_t;
    localparam state_t IDLE = 2'd0;
    localparam state_t RUN  = 2'd1;
    localparam state_t PEND = 2'd2;

endpackage

// File: rtl/freq_div_core.sv
// Period counter and registered clk_out/tick generation for one divisor.
// The counter holds the phase of the cycle currently shown on clk_out.
module freq_div_core #(
    parameter int unsigned DIV_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run,
    input  logic             load,
    input  logic [DIV_W-1:0] div,
    output logic             clk_out,
    output logic             tick,
    output logic             boundary
);

    logic [DIV_W-1:0] cnt_q, cnt_d, cnt_inc;
    logic             clk_out_q, clk_out_d;
    logic             tick_q, tick_d;

    assign cnt_inc  = cnt_q + DIV_W'(1);
    // div is always the applied divisor, so the wrap point never sees an unapplied value.
    assign boundary = run && (cnt_q == div - DIV_W'(1));

    // Next phase: load restarts at phase 0 (always high for div >= 2), otherwise count or park.
    always_comb begin
        cnt_d     = '0;
        clk_out_d = 1'b0;
        tick_d    = 1'b0;
        if (load) begin
            clk_out_d = 1'b1;
            tick_d    = 1'b1;
        end else if (run && !boundary) begin
            cnt_d     = cnt_inc;
            clk_out_d = cnt_inc < (div >> 1);
        end
    end

    // Phase and output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q     <= '0;
            clk_out_q <= 1'b0;
            tick_q    <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            clk_out_q <= clk_out_d;
            tick_q    <= tick_d;
        end
    end

    assign clk_out = clk_out_q;
    assign tick    = tick_q;

endmodule

// File: rtl/freq_div_ctrl.sv
// Divider controller: start/stop FSM and valid/ready divisor handshake.
// A divisor offered while running is parked until the next period boundary.
module freq_div_ctrl #(
    parameter int unsigned DIV_W   = 8,
    parameter int unsigned DEF_DIV = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             cfg_valid,
    input  logic [DIV_W-1:0] cfg_div,
    output logic             cfg_ready,
    output logic             cfg_err,
    output logic             clk_out,
    output logic             tick,
    output logic [DIV_W-1:0] cur_div,
    output logic             busy
);

    import freq_div_pkg::*;

    localparam logic [DIV_W-1:0] DefDiv = DIV_W'(DEF_DIV);
    localparam logic [DIV_W-1:0] MinDiv = DIV_W'(DIV_MIN);

    state_t           state_q, state_d;
    logic [DIV_W-1:0] cur_div_q, cur_div_d;
    logic [DIV_W-1:0] pend_div_q, pend_div_d;
    logic             cfg_err_q;
    logic             xfer, cfg_bad, cfg_ok;
    logic             load, boundary;

    assign cfg_ready = (state_q != PEND);
    assign busy      = (state_q != IDLE);
    assign xfer      = cfg_valid && cfg_ready;
    assign cfg_bad   = xfer && (cfg_div < MinDiv);
    assign cfg_ok    = xfer && !cfg_bad;

    // FSM next state, divisor staging and core restart strobe.
    always_comb begin
        state_d    = state_q;
        cur_div_d  = cur_div_q;
        pend_div_d = pend_div_q;
        load       = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (cfg_ok) cur_div_d = cfg_div;
                if (enable) begin
                    state_d = RUN;
                    load    = 1'b1;
                end
            end
            RUN: begin
                if (boundary) begin
                    // A divisor arriving on the boundary edge governs the very next period.
                    if (cfg_ok) cur_div_d = cfg_div;
                    if (enable) load    = 1'b1;
                    else        state_d = IDLE;
                end else if (cfg_ok) begin
                    pend_div_d = cfg_div;
                    state_d    = PEND;
                end
            end
            PEND: begin
                if (boundary) begin
                    cur_div_d  = pend_div_q;
                    pend_div_d = '0;
                    load       = enable;
                    state_d    = enable ? RUN : IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Controller state registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            cur_div_q  <= DefDiv;
            pend_div_q <= '0;
            cfg_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cur_div_q  <= cur_div_d;
            pend_div_q <= pend_div_d;
            cfg_err_q  <= cfg_bad;
        end
    end

    assign cfg_err = cfg_err_q;
    assign cur_div = cur_div_q;

    freq_div_core #(
        .DIV_W (DIV_W)
    ) u_core (
        .clk      (clk),
        .rst      (rst),
        .run      (busy),
        .load     (load),
        .div      (cur_div_q),
        .clk_out  (clk_out),
        .tick     (tick),
        .boundary (boundary)
    );

endmodule
